awb_gain_estimator: RTL
=======================

# awb_gain_estimator

Gray-world automatic white-balance statistics and gain engine, upstream of the per-pixel white-balance gain stage. Accumulates per-channel R/G/B sums over each frame delimited by start/end flags. At end of frame it divides the green sum by the red and blue sums and publishes per-channel fixed-point gains. The gain stage applies these gains to the following frame.

## Interface
- P_SUM_W, 32: per-channel accumulator width (bits); saturating.
- P_GAIN_W, 8: gain output width (bits).
- P_GAIN_FRAC, 6: fractional bits of gain (Q2.6 by default; unity = 1<<P_GAIN_FRAC = 64).
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_color_r / i_color_g / i_color_b  in  8 each  pixel components.
- i_pixel_valid  in  1  qualifies the pixel on this cycle.
- i_start_frame_flag  in  1  one-cycle pulse marking the first pixel of a frame.
- i_end_frame_flag  in  1  one-cycle pulse marking the last pixel of a frame.
- o_gain_r / o_gain_g / o_gain_b  out  P_GAIN_W each  current gains, unsigned Q(P_GAIN_W-P_GAIN_FRAC).P_GAIN_FRAC.
- o_gain_valid  out  1  one-cycle pulse when gains are updated.
- o_busy  out  1  high while the divider runs.
- o_frame_dropped  out  1  one-cycle pulse when an end-of-frame is discarded.

## Operation
- Reset (i_rst=0 at an edge):
  - o_gain_r/g/b = unity (64).
  - o_gain_valid, o_busy, o_frame_dropped = 0.
  - Accumulators and snapshots = 0; in_frame = 0; FSM = IDLE.
- Reset has priority over everything, including mid-division. Division is abandoned and gains return to unity.
- Accumulation (independent of FSM):
  - Start flag: accumulators load the current pixel if i_pixel_valid, else 0. Sets in_frame.
  - in_frame and i_pixel_valid: accumulators add the pixel. They saturate at 2^P_SUM_W-1; no wrap.
  - Pixels outside in_frame are ignored.
- End of frame:
  - i_end_frame_flag with in_frame: the pixel on that cycle is included. Final sums are copied to snapshot registers and in_frame clears.
  - End flag with in_frame=0 is ignored; no pulse.
  - Start and end in the same cycle form a one-pixel frame. Snapshot = that pixel only; accumulators restart at 0 with in_frame=0.
- FSM states: IDLE, DIV, UPDATE.
  - IDLE -> DIV on an accepted end-of-frame. Snapshot sums are loaded and o_busy=1.
  - DIV runs two parallel restoring dividers, one quotient bit per cycle, for N = P_SUM_W+P_GAIN_FRAC cycles (38 by default).
    - Red divider: dividend = sum_g << P_GAIN_FRAC, divisor = sum_r.
    - Blue divider: dividend = sum_g << P_GAIN_FRAC, divisor = sum_b.
  - DIV -> UPDATE after N cycles.
  - UPDATE -> IDLE after one cycle. In UPDATE:
    - Quotients above 2^P_GAIN_W-1 saturate to 2^P_GAIN_W-1 (255).
    - A zero divisor yields unity for that channel.
    - o_gain_g is always unity.
    - Gains are registered and o_gain_valid pulses.
- Accepted end-of-frame while o_busy=1: snapshot is not overwritten, o_frame_dropped pulses, and the current division completes unaffected. Accumulation of the new frame is unaffected.
- Gains hold between updates.

## Timing
- End flag sampled at edge 0.
- Division occupies cycles 1..N; o_busy is high for cycles 1..N+1.
- New gains and the o_gain_valid pulse appear at edge N+2 (40 by default); o_busy falls at the same edge.
- A start flag in the cycle after an end flag is legal, with no blanking requirement. The minimum frame period for no drops is N+2 cycles.

## Configuration
- AWB_TEMPORAL_SMOOTH_EN defined: UPDATE writes o_gain_x = (3*old + new) >> 2 per channel instead of the saturated quotient. The sum is computed at P_GAIN_W+2 bits and truncated. Latency is unchanged; reset value is still unity.
- Not defined: UPDATE writes the saturated quotient directly.

## Test plan
- Gray frame of 4 valid pixels (r=g=b=100): after edge 40, gains 64/64/64 and a single o_gain_valid pulse.
- 4 pixels r=64, g=128, b=32: gain_r=128 (2.0); gain_b saturates to 255; gain_g=64.
- Frame with all b=0 and r=g=50: gain_b=64 (zero-divisor unity), gain_r=64. Also a one-pixel frame (start and end together): result matches that pixel.
- Second end-of-frame 10 cycles after the first: o_frame_dropped pulses once, first result is still published at edge 40, and the third frame accumulates correctly. Reset asserted at division cycle 20: outputs unity, no o_gain_valid.
- Frame with i_pixel_valid low on half the cycles and pixels outside in_frame: only qualified in-frame pixels are counted. An end flag with no preceding start produces no pulse.
- AWB_TEMPORAL_SMOOTH_EN: gain_r at 64, new quotient 128 -> 80; repeated -> 92.

Source files
------------

// File: rtl/awb_gain_estimator_if.sv
// Pixel stream input and white-balance gain result bundle for awb_gain_estimator.
interface awb_gain_estimator_if #(
  parameter int unsigned P_GAIN_W = 8
) ();
  logic [7:0]          i_color_r;
  logic [7:0]          i_color_g;
  logic [7:0]          i_color_b;
  logic                i_pixel_valid;
  logic                i_start_frame_flag;
  logic                i_end_frame_flag;
  logic [P_GAIN_W-1:0] o_gain_r;
  logic [P_GAIN_W-1:0] o_gain_g;
  logic [P_GAIN_W-1:0] o_gain_b;
  logic                o_gain_valid;
  logic                o_busy;
  logic                o_frame_dropped;

  modport master (
    output i_color_r, i_color_g, i_color_b, i_pixel_valid,
    output i_start_frame_flag, i_end_frame_flag,
    input  o_gain_r, o_gain_g, o_gain_b, o_gain_valid, o_busy, o_frame_dropped
  );

  modport slave (
    input  i_color_r, i_color_g, i_color_b, i_pixel_valid,
    input  i_start_frame_flag, i_end_frame_flag,
    output o_gain_r, o_gain_g, o_gain_b, o_gain_valid, o_busy, o_frame_dropped
  );
endinterface

// File: rtl/awb_gain_estimator.sv
// Gray-world AWB: per-frame R/G/B sums, two restoring dividers, fixed-point gains.
// Optional AWB_TEMPORAL_SMOOTH_EN blends new gains as (3*old + new) >> 2.
module awb_gain_estimator #(
  parameter int unsigned P_SUM_W     = 32,
  parameter int unsigned P_GAIN_W    = 8,
  parameter int unsigned P_GAIN_FRAC = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  awb_gain_estimator_if.slave  bus
);
  localparam int unsigned DVD_W   = P_SUM_W + P_GAIN_FRAC;
  localparam int unsigned N_STEPS = DVD_W;
  localparam int unsigned CNT_W   = $clog2(N_STEPS + 1);
  localparam int unsigned REM_W   = P_SUM_W;
  localparam logic [P_GAIN_W-1:0] GAIN_UNITY = P_GAIN_W'(1) << P_GAIN_FRAC;
  localparam logic [P_GAIN_W-1:0] GAIN_MAX   = '1;
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(N_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIV    = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 go_q, go_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 in_frame_q, in_frame_d;
  logic [P_SUM_W-1:0]   acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
  logic [P_SUM_W-1:0]   snap_r_q, snap_r_d, snap_g_q, snap_g_d, snap_b_q, snap_b_d;
  logic [REM_W-1:0]     rem_r_q, rem_r_d, rem_b_q, rem_b_d;
  logic [DVD_W-1:0]     quo_r_q, quo_r_d, quo_b_q, quo_b_d;
  logic [P_GAIN_W-1:0]  gain_r_q, gain_r_d, gain_g_q, gain_g_d, gain_b_q, gain_b_d;
  logic                 gain_valid_q, gain_valid_d;
  logic                 busy_q, busy_d;
  logic                 dropped_q, dropped_d;

  logic [7:0]           pix_r, pix_g, pix_b;
  logic [P_SUM_W-1:0]   fin_r, fin_g, fin_b;
  logic                 eof_accept;
  logic                 div_busy;
  logic                 snap_load;
  logic [P_GAIN_W-1:0]  q_r, q_b;

  function automatic logic [P_SUM_W-1:0] sat_add(input logic [P_SUM_W-1:0] a,
                                                 input logic [7:0]         b);
    logic [P_SUM_W:0] s;
    s = {1'b0, a} + (P_SUM_W + 1)'(b);
    return s[P_SUM_W] ? '1 : s[P_SUM_W-1:0];
  endfunction

  // One restoring-division step: returns {next remainder, next quotient/dividend shift reg}.
  function automatic logic [REM_W+DVD_W-1:0] div_step(input logic [REM_W-1:0]   rem,
                                                      input logic [DVD_W-1:0]   quo,
                                                      input logic [P_SUM_W-1:0] dsr);
    logic [REM_W:0] trial;
    logic           qbit;
    trial = {rem, quo[DVD_W-1]};
    qbit  = (trial >= {1'b0, dsr});
    if (qbit) begin
      trial = trial - {1'b0, dsr};
    end
    return {trial[REM_W-1:0], quo[DVD_W-2:0], qbit};
  endfunction

  function automatic logic [P_GAIN_W-1:0] sat_gain(input logic [DVD_W-1:0] q,
                                                   input logic             dz);
    if (dz) begin
      return GAIN_UNITY;
    end
    if (q > DVD_W'(GAIN_MAX)) begin
      return GAIN_MAX;
    end
    return q[P_GAIN_W-1:0];
  endfunction

`ifdef AWB_TEMPORAL_SMOOTH_EN
  function automatic logic [P_GAIN_W-1:0] blend(input logic [P_GAIN_W-1:0] old_g,
                                                input logic [P_GAIN_W-1:0] new_g);
    logic [P_GAIN_W+1:0] s;
    s = ((P_GAIN_W + 2)'(old_g) << 1) + (P_GAIN_W + 2)'(old_g) + (P_GAIN_W + 2)'(new_g);
    return s[P_GAIN_W+1:2];
  endfunction
`endif

  // Frame accumulation and snapshot capture, independent of the divider FSM.
  always_comb begin
    pix_r      = bus.i_pixel_valid ? bus.i_color_r : 8'd0;
    pix_g      = bus.i_pixel_valid ? bus.i_color_g : 8'd0;
    pix_b      = bus.i_pixel_valid ? bus.i_color_b : 8'd0;
    fin_r      = bus.i_start_frame_flag ? P_SUM_W'(pix_r) : sat_add(acc_r_q, pix_r);
    fin_g      = bus.i_start_frame_flag ? P_SUM_W'(pix_g) : sat_add(acc_g_q, pix_g);
    fin_b      = bus.i_start_frame_flag ? P_SUM_W'(pix_b) : sat_add(acc_b_q, pix_b);
    eof_accept = bus.i_end_frame_flag && (bus.i_start_frame_flag || in_frame_q);
    div_busy   = go_q || (state_q == ST_DIV);
    snap_load  = eof_accept && !div_busy;
    go_d       = snap_load;
    dropped_d  = eof_accept && div_busy;

    acc_r_d    = acc_r_q;
    acc_g_d    = acc_g_q;
    acc_b_d    = acc_b_q;
    in_frame_d = in_frame_q;
    if (bus.i_start_frame_flag) begin
      acc_r_d    = bus.i_end_frame_flag ? '0 : fin_r;
      acc_g_d    = bus.i_end_frame_flag ? '0 : fin_g;
      acc_b_d    = bus.i_end_frame_flag ? '0 : fin_b;
      in_frame_d = !bus.i_end_frame_flag;
    end else if (in_frame_q) begin
      acc_r_d    = bus.i_end_frame_flag ? '0 : fin_r;
      acc_g_d    = bus.i_end_frame_flag ? '0 : fin_g;
      acc_b_d    = bus.i_end_frame_flag ? '0 : fin_b;
      in_frame_d = !bus.i_end_frame_flag;
    end

    snap_r_d = snap_load ? fin_r : snap_r_q;
    snap_g_d = snap_load ? fin_g : snap_g_q;
    snap_b_d = snap_load ? fin_b : snap_b_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (go_q) state_d = ST_DIV;
      ST_DIV:    if (cnt_q == CNT_LAST) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Divider datapath and gain publication driven by the current state.
  always_comb begin
    cnt_d        = cnt_q;
    rem_r_d      = rem_r_q;
    rem_b_d      = rem_b_q;
    quo_r_d      = quo_r_q;
    quo_b_d      = quo_b_q;
    gain_r_d     = gain_r_q;
    gain_g_d     = gain_g_q;
    gain_b_d     = gain_b_q;
    gain_valid_d = 1'b0;
    busy_d       = (state_d != ST_IDLE);
    q_r          = sat_gain(quo_r_q, snap_r_q == '0);
    q_b          = sat_gain(quo_b_q, snap_b_q == '0);
    case (state_q)
      ST_IDLE: begin
        if (go_q) begin
          cnt_d   = '0;
          rem_r_d = '0;
          rem_b_d = '0;
          quo_r_d = {snap_g_q, {P_GAIN_FRAC{1'b0}}};
          quo_b_d = {snap_g_q, {P_GAIN_FRAC{1'b0}}};
        end
      end
      ST_DIV: begin
        {rem_r_d, quo_r_d} = div_step(rem_r_q, quo_r_q, snap_r_q);
        {rem_b_d, quo_b_d} = div_step(rem_b_q, quo_b_q, snap_b_q);
        cnt_d              = cnt_q + CNT_W'(1);
      end
      ST_UPDATE: begin
`ifdef AWB_TEMPORAL_SMOOTH_EN
        gain_r_d = blend(gain_r_q, q_r);
        gain_g_d = blend(gain_g_q, GAIN_UNITY);
        gain_b_d = blend(gain_b_q, q_b);
`else
        gain_r_d = q_r;
        gain_g_d = GAIN_UNITY;
        gain_b_d = q_b;
`endif
        gain_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      go_q         <= 1'b0;
      cnt_q        <= '0;
      in_frame_q   <= 1'b0;
      acc_r_q      <= '0;
      acc_g_q      <= '0;
      acc_b_q      <= '0;
      snap_r_q     <= '0;
      snap_g_q     <= '0;
      snap_b_q     <= '0;
      rem_r_q      <= '0;
      rem_b_q      <= '0;
      quo_r_q      <= '0;
      quo_b_q      <= '0;
      gain_r_q     <= GAIN_UNITY;
      gain_g_q     <= GAIN_UNITY;
      gain_b_q     <= GAIN_UNITY;
      gain_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      go_q         <= go_d;
      cnt_q        <= cnt_d;
      in_frame_q   <= in_frame_d;
      acc_r_q      <= acc_r_d;
      acc_g_q      <= acc_g_d;
      acc_b_q      <= acc_b_d;
      snap_r_q     <= snap_r_d;
      snap_g_q     <= snap_g_d;
      snap_b_q     <= snap_b_d;
      rem_r_q      <= rem_r_d;
      rem_b_q      <= rem_b_d;
      quo_r_q      <= quo_r_d;
      quo_b_q      <= quo_b_d;
      gain_r_q     <= gain_r_d;
      gain_g_q     <= gain_g_d;
      gain_b_q     <= gain_b_d;
      gain_valid_q <= gain_valid_d;
      busy_q       <= busy_d;
      dropped_q    <= dropped_d;
    end
  end

  assign bus.o_gain_r        = gain_r_q;
  assign bus.o_gain_g        = gain_g_q;
  assign bus.o_gain_b        = gain_b_q;
  assign bus.o_gain_valid    = gain_valid_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_frame_dropped = dropped_q;

endmodule
